// File: rtl/seq_alu.sv
// Handshaked ALU: logic/arith ops in 1 cycle, shifts/rotates 1 bit per cycle (latency 1+n); result held until out_ready.
// Define ALU_OVF_EN to add the registered signed-overflow output ovf.
module seq_alu #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             cout,
  output logic             Z
`ifdef ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_MASK = 4'd7;
  localparam logic [3:0] OP_ADDS = 4'd8;
  localparam logic [3:0] OP_SHL  = 4'd9;
  localparam logic [3:0] OP_SHR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;

  localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] work;
  logic [CNT_W-1:0] count;
  logic             accept;

  logic [WIDTH-1:0] res_c;
  logic             cout_c;
  logic             is_shift;
  logic [CNT_W-1:0] n_c;
  logic [WIDTH:0]   wa, wb, wc, mag, sum;

  logic [WIDTH-1:0] work_nx;
  logic             out_bit;

  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  // Result of the operation presented at the inputs, used on the accept edge.
  always_comb begin
    res_c    = '0;
    cout_c   = 1'b0;
    is_shift = 1'b0;
    n_c      = '0;
    wa       = {1'b0, alu_in1};
    wb       = {1'b0, alu_in2};
    wc       = {{WIDTH{1'b0}}, cin};
    mag      = {2'b00, alu_in2[WIDTH-2:0]};
    sum      = '0;
    case (opcode)
      OP_ADD:  begin sum = wa + wb;      res_c = sum[WIDTH-1:0]; cout_c = sum[WIDTH]; end
      OP_ADDC: begin sum = wa + wb + wc; res_c = sum[WIDTH-1:0]; cout_c = sum[WIDTH]; end
      // Borrow shows up as the sign of the zero-extended difference.
      OP_SUB:  begin sum = wa - wb;      res_c = sum[WIDTH-1:0]; cout_c = sum[WIDTH]; end
      OP_SUBC: begin sum = wa - wb - wc; res_c = sum[WIDTH-1:0]; cout_c = sum[WIDTH]; end
      OP_AND:  res_c = alu_in1 & alu_in2;
      OP_OR:   res_c = alu_in1 | alu_in2;
      OP_XOR:  res_c = alu_in1 ^ alu_in2;
      OP_MASK: res_c = ~(alu_in1 & alu_in2);
      OP_ADDS: begin
        sum   = alu_in2[WIDTH-1] ? (wa - mag) : (wa + mag);
        res_c = sum[WIDTH-1:0];
      end
      OP_SHL, OP_SHR: begin
        is_shift = 1'b1;
        res_c    = alu_in1;
        n_c      = (alu_in2 >= W_VAL) ? CNT_W'(WIDTH) : CNT_W'(alu_in2);
      end
      OP_ROL, OP_ROR: begin
        is_shift = 1'b1;
        res_c    = alu_in1;
        n_c      = CNT_W'(alu_in2 % W_VAL);
      end
      default: ;
    endcase
  end

`ifdef ALU_OVF_EN
  logic [WIDTH:0] sa, sb, sres;
  logic           ovf_c;

  always_comb begin
    sa    = {alu_in1[WIDTH-1], alu_in1};
    sb    = {alu_in2[WIDTH-1], alu_in2};
    sres  = '0;
    ovf_c = 1'b0;
    case (opcode)
      OP_ADD:  begin sres = sa + sb;      ovf_c = sres[WIDTH] ^ sres[WIDTH-1]; end
      OP_ADDC: begin sres = sa + sb + wc; ovf_c = sres[WIDTH] ^ sres[WIDTH-1]; end
      OP_SUB:  begin sres = sa - sb;      ovf_c = sres[WIDTH] ^ sres[WIDTH-1]; end
      OP_SUBC: begin sres = sa - sb - wc; ovf_c = sres[WIDTH] ^ sres[WIDTH-1]; end
      default: ;
    endcase
  end
`endif

  always_comb begin
    work_nx = work;
    out_bit = 1'b0;
    case (op_q)
      OP_SHL: begin work_nx = {work[WIDTH-2:0], 1'b0};        out_bit = work[WIDTH-1]; end
      OP_SHR: begin work_nx = {1'b0, work[WIDTH-1:1]};        out_bit = work[0];       end
      OP_ROL: work_nx = {work[WIDTH-2:0], work[WIDTH-1]};
      OP_ROR: work_nx = {work[0], work[WIDTH-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      alu_out   <= '0;
      cout      <= 1'b0;
      Z         <= 1'b0;
      count     <= '0;
      work      <= '0;
      op_q      <= '0;
`ifdef ALU_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (out_valid & out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
          if (accept) begin
            op_q  <= opcode;
            work  <= alu_in1;
            count <= n_c;
            if (is_shift && (n_c != '0)) begin
              state     <= SHIFT;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              alu_out   <= res_c;
              cout      <= cout_c;
              Z         <= (res_c == '0);
`ifdef ALU_OVF_EN
              ovf       <= ovf_c;
`endif
            end
          end
        end
        SHIFT: begin
          work  <= work_nx;
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            alu_out   <= work_nx;
            cout      <= out_bit;
            Z         <= (work_nx == '0);
`ifdef ALU_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboarded bench for seq_alu: driver pushes model results on accept, monitor pops on retire.
module tb_seq_alu;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, cin, cout, Z;
  logic [3:0]   opcode;
  logic [W-1:0] alu_in1, alu_in2, alu_out;
`ifdef ALU_OVF_EN
  logic         ovf;
`endif

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_in1(alu_in1), .alu_in2(alu_in2), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .alu_out(alu_out),
    .cout(cout), .Z(Z)
`ifdef ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int res;
    int co;
    int ov;
    int lat;
    int acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  int   npushed = 0;
  int   nres = 0;
  bit   rand_bp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act == req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference behaviour from the operation definitions, using plain integer arithmetic.
  function automatic void model(input int op, input int a, input int b, input int c,
                                output int res, output int co, output int ov, output int lat);
    int mask, n, t, sa, sbv;
    mask = (1 << W) - 1;
    sa   = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sbv  = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    res = 0; co = 0; ov = 0; lat = 1; t = 0;
    case (op)
      0: begin res = (a + b) & mask;     co = (a + b) >> W;     t = sa + sbv; end
      1: begin res = (a + b + c) & mask; co = (a + b + c) >> W; t = sa + sbv + c; end
      2: begin res = (a - b) & mask;     co = (a < b) ? 1 : 0;     t = sa - sbv; end
      3: begin res = (a - b - c) & mask; co = (a < b + c) ? 1 : 0; t = sa - sbv - c; end
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      7: res = ~(a & b) & mask;
      8: begin
        n = b & ((1 << (W-1)) - 1);
        res = ((b >> (W-1)) != 0) ? ((a - n) & mask) : ((a + n) & mask);
      end
      9: begin
        n = (b > W) ? W : b; lat = 1 + n;
        res = (a << n) & mask; co = (n > 0) ? ((a << n) >> W) & 1 : 0;
      end
      10: begin
        n = (b > W) ? W : b; lat = 1 + n;
        res = a >> n; co = (n > 0) ? (a >> (n - 1)) & 1 : 0;
      end
      11: begin
        n = b % W; lat = 1 + n;
        res = (n == 0) ? a : (((a << n) | (a >> (W - n))) & mask);
      end
      12: begin
        n = b % W; lat = 1 + n;
        res = (n == 0) ? a : (((a >> n) | (a << (W - n))) & mask);
      end
      default: ;
    endcase
    if (op <= 3) ov = (t < -(1 << (W-1)) || t > (1 << (W-1)) - 1) ? 1 : 0;
  endfunction

  task automatic issue(input int op, input int a, input int b, input int c, output int waited);
    exp_t e;
    int   res, co, ov, lat;
    waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    opcode   = 4'(op);
    alu_in1  = W'(a);
    alu_in2  = W'(b);
    cin      = c[0];
    #1;
    while (!in_ready && waited < 60) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    model(op, a, b, c, res, co, ov, lat);
    e.res = res; e.co = co; e.ov = ov; e.lat = lat; e.acc_cyc = cyc + 1;
    sb.push_back(e);
    npushed++;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Backpressure generator for the random phase.
  initial forever begin
    @(negedge clk);
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Monitor: latency and hold checks while valid, full compare on retire.
  initial begin
    bit   seen;
    int   held;
    exp_t e;
    seen = 0; held = 0;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        seen = 0;
      end else if (out_valid) begin
        if (!seen) begin
          seen = 1;
          held = {alu_out, cout, Z};
          check("unexpected_result", (sb.size() > 0) ? 1 : 0, 1);
          if (sb.size() > 0) check("latency", cyc - sb[0].acc_cyc + 1, sb[0].lat);
        end else begin
          check("hold_stable", int'({alu_out, cout, Z}), held);
        end
        if (!out_ready) check("in_ready_bp", int'(in_ready), 0);
        if (out_ready) begin
          nres++;
          seen = 0;
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("alu_out", int'(alu_out), e.res);
            check("cout", int'(cout), e.co);
            check("Z", int'(Z), (e.res == 0) ? 1 : 0);
`ifdef ALU_OVF_EN
            check("ovf", int'(ovf), e.ov);
`endif
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w;
    rst = 1'b1; in_valid = 1'b0; opcode = '0; alu_in1 = '0; alu_in2 = '0; cin = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_alu_out", int'(alu_out), 0);
    check("rst_cout", int'(cout), 0);
    check("rst_Z", int'(Z), 0);
    check("rst_in_ready", int'(in_ready), 1);
`ifdef ALU_OVF_EN
    check("rst_ovf", int'(ovf), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    issue(0, 'hF0, 'h20, 0, w);
    issue(2, 'h03, 'h05, 0, w);
    check("b2b_in_ready", w, 0);
    issue(2, 'h05, 'h05, 0, w);
    issue(8, 'h10, 'h83, 0, w);

    issue(9, 'h81, 3, 0, w);
    in_valid = 1'b1; opcode = 4'd0; alu_in1 = 8'h01; alu_in2 = 8'h01;
    for (int i = 0; i < 3; i++) begin
      check("in_ready_shift", int'(in_ready), 0);
      if (i == 2) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    issue(10, 'h81, 1, 0, w);

    issue(9, 'h01, 200, 0, w);
    issue(12, 'h01, 9, 0, w);
    issue(11, 'hA5, 0, 0, w);

    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    issue(1, 'h12, 'h34, 1, w);
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk); #3;
    check("retire_1cycle", int'(out_valid), 0);

    issue(9, 'hA5, 5, 0, w);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    npushed--;
    @(negedge clk); #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_alu_out", int'(alu_out), 0);
    check("abort_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    issue(0, 'h01, 'h01, 0, w);
    issue(0, 'h7F, 'h01, 0, w);
    issue(3, 'h00, 'h7F, 1, w);

    rand_bp = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
            ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), w);
    end
    rand_bp = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    check("result_count", nres, npushed);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
